serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Framed serial-to-parallel receiver: the far end of the universal shift register's PISO modes. It samples a one-bit-per-enabled-clock stream, recognises start/data/parity/stop framing, and reassembles the 16-bit word in either bit order. The word is presented on a valid/ready parallel port backed by a one-entry holding register, with per-word error flags and an overrun pulse.

## Interface
- WIDTH, 16, data bits per frame (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_din  in  1  serial data; line idles high
- s_en  in  1  bit qualifier; s_din sampled only on edges where s_en=1
- msb_first  in  1  1: first data bit lands in p_dout[WIDTH-1] (left-shift order); 0: first bit lands in p_dout[0] (right-shift order)
- p_dout  out  WIDTH  received word
- dout_valid  out  1  p_dout and flags valid
- dout_ready  in  1  consumer accepts word when dout_valid=1
- parity_err  out  1  parity mismatch for the word on p_dout
- frame_err  out  1  stop bit was 0 for the word on p_dout
- overrun  out  1  one-cycle pulse: a completed frame was dropped
- busy  out  1  high while a frame is in progress (state≠IDLE)

## Operation
- Frame = start(0), WIDTH data bits, even-parity bit, stop(1): WIDTH+3 enabled samples.
- FSM states: IDLE, DATA, PARITY, STOP. A state advances only on an edge with s_en=1; with s_en=0, all state, counter and shift register hold.
- IDLE: s_din=0 → DATA; bit counter cleared; msb_first latched for the whole frame. s_din=1 → stay in IDLE.
- DATA: shift in one bit per sample.
  - Latched msb_first=1: sreg ← {sreg[WIDTH-2:0], s_din}.
  - Latched msb_first=0: sreg ← {s_din, sreg[WIDTH-1:1]}.
  - After the WIDTH-th bit → PARITY.
- PARITY: perr ← s_din ^ (^sreg), so 1 = error → STOP.
- STOP: ferr ← ~s_din. The frame is complete → IDLE. A 0 stop bit is never reinterpreted as a start bit.
- Completion write:
  - If the holding register is empty, or is being drained on this same edge (dout_valid & dout_ready), load p_dout/parity_err/frame_err and set dout_valid.
  - Otherwise drop the new frame, keep the held word unchanged, and pulse overrun.
- Frames with errors are still delivered, with their flags set.
- Handshake:
  - Word is consumed on any edge with dout_valid & dout_ready; dout_valid clears unless a simultaneous completion reloads it.
  - p_dout and flags are stable while dout_valid=1 and the word is unaccepted.
  - dout_ready is ignored while dout_valid=0.

## Timing
- Reset (async assert, any state including mid-frame):
  - State returns to IDLE; partial frame discarded.
  - p_dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- busy rises the cycle after the start-bit sample and falls the cycle after the stop-bit sample.
- dout_valid rises the cycle after the edge that samples the stop bit.
  - Minimum start-to-valid latency is WIDTH+3 enabled edges.
  - Back-to-back frames need no idle bit between them.
- overrun is high for exactly the one cycle after the dropping edge.
- Simultaneous accept + completion: the new word is loaded, dout_valid stays 1, and there is no overrun.
- msb_first changes mid-frame take effect on the next frame only.

## Structure
- Package serial_frame_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP)
  - DEFAULT_WIDTH=16
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1
  - counter width $clog2(WIDTH+1)
- The transmitter side reuses this package.
- One sub-module: rx_hold_reg. It is the one-entry valid/ready holding register with data+flags, load/accept logic and overrun generation. The FSM and shift register stay in the top.

## Test plan
- MSB-first 16'hA5C3, parity 0, stop 1, s_en=1 continuous, dout_ready=1 → p_dout=16'hA5C3, dout_valid for one cycle 19 edges after the start-bit edge, parity_err=0, frame_err=0.
- LSB-first 16'h0001 (bits sent 1,0,…,0), parity 1, s_en toggling 1,0,1,0 → p_dout=16'h0001, no errors, total latency 38 clocks.
- 16'hA5C3 with parity bit 1, then a second frame with stop bit 0 → word 1 has parity_err=1, frame_err=0; word 2 has frame_err=1. The receiver returns to IDLE and is not restarted by the 0 stop bit.
- dout_ready=0, two back-to-back frames 16'h1234 then 16'hFFFF → p_dout holds 16'h1234, overrun pulses once. Then dout_ready=1 → 16'h1234 accepted, dout_valid=0.
- dout_ready asserted on exactly the stop-bit edge of frame 2 while word 1 is held → word 1 accepted, p_dout=word 2, dout_valid stays 1, overrun=0.
- rst_n pulsed low after 8 data bits, then a full frame 16'h00FF → all outputs 0 during reset; only 16'h00FF is delivered, with no errors.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared framing definitions for the serial frame receiver and transmitter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int   DEFAULT_WIDTH = 16;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam logic IDLE_LEVEL    = 1'b1;

    // Bit counter must hold values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready holding register for a received word and its error flags.
// Latency: word visible the cycle after load; a same-edge accept lets a new load through.
// Backpressure: a load while full and not draining is dropped and overrun pulses one cycle.
module rx_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             load_perr,
    input  logic             load_ferr,
    output logic [WIDTH-1:0] p_dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    logic accept;
    logic take;

    assign accept = dout_valid & dout_ready;
    assign take   = load & (~dout_valid | dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_dout     <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= load & ~take;
            if (take) begin
                p_dout     <= load_dat;
                parity_err <= load_perr;
                frame_err  <= load_ferr;
                dout_valid <= 1'b1;
            end else if (accept) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial-to-parallel receiver: start, WIDTH data bits, even parity, stop.
// Latency: word valid the cycle after the stop-bit sample (WIDTH+3 enabled edges from start).
// Backpressure: one-entry holding register; frames completing while it is full are dropped with overrun.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_din,
    input  logic             s_en,
    input  logic             msb_first,
    output logic [WIDTH-1:0] p_dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             msb_lat, msb_nxt;
    logic             perr, perr_nxt;
    logic             frame_done;
    logic             stop_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            msb_lat <= 1'b0;
            perr    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sreg    <= sreg_nxt;
            msb_lat <= msb_nxt;
            perr    <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sreg_nxt   = sreg;
        msb_nxt    = msb_lat;
        perr_nxt   = perr;
        frame_done = 1'b0;
        stop_err   = 1'b0;
        if (s_en) begin
            case (state)
                IDLE: begin
                    if (s_din == START_BIT) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        msb_nxt   = msb_first;
                    end
                end
                DATA: begin
                    sreg_nxt = msb_lat ? {sreg[WIDTH-2:0], s_din} : {s_din, sreg[WIDTH-1:1]};
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    perr_nxt  = s_din ^ (^sreg);
                    state_nxt = STOP;
                end
                STOP: begin
                    // Always return to IDLE: a low stop bit is a framing error, not a new start.
                    frame_done = 1'b1;
                    stop_err   = (s_din != STOP_BIT);
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    rx_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (frame_done),
        .load_dat   (sreg),
        .load_perr  (perr),
        .load_ferr  (stop_err),
        .p_dout     (p_dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized and directed bench for serial_frame_rx against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         s_din = 1'b1;
    logic         s_en = 1'b0;
    logic         msb_first = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] p_dout;
    logic         dout_valid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Reference model: contents of the one-entry output slot plus the frame in flight.
    bit           m_vld = 1'b0;
    logic [W-1:0] m_dat = '0;
    bit           m_perr = 1'b0;
    bit           m_ferr = 1'b0;
    logic [W-1:0] n_dat;
    bit           n_perr;
    bit           n_ferr;
    int           ovr_seen = 0;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_din      (s_din),
        .s_en       (s_en),
        .msb_first  (msb_first),
        .p_dout     (p_dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, then compare.
    task automatic tick(input logic din, input logic en, input logic rdy,
                        input bit done, input bit exp_busy);
        bit exp_ovr;
        s_din      = din;
        s_en       = en;
        dout_ready = rdy;
        @(posedge clk);
        exp_ovr = 1'b0;
        if (done) begin
            if (!m_vld || rdy) begin
                m_vld  = 1'b1;
                m_dat  = n_dat;
                m_perr = n_perr;
                m_ferr = n_ferr;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        #1;
        if (overrun) ovr_seen++;
        chk("dout_valid", dout_valid, m_vld);
        chk("overrun", overrun, exp_ovr);
        chk("busy", busy, exp_busy);
        if (m_vld) begin
            chk("p_dout", p_dout, m_dat);
            chk("parity_err", parity_err, m_perr);
            chk("frame_err", frame_err, m_ferr);
        end
    endtask

    // mode 0: never ready, 1: always, 2: random, 3: only on the stop-bit edge
    function automatic logic rdy_for(input int mode, input bit stop_edge);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'($urandom_range(0, 1));
            default: return logic'(stop_edge);
        endcase
    endfunction

    // en_mode 0: continuous, 1: one idle qualifier after each bit, 2: 0..2 random gaps
    task automatic send_frame(input logic [W-1:0] d, input bit msb, input bit pbit,
                              input bit stopb, input int en_mode, input int rmode,
                              input int nbits);
        logic b;
        bit   last;
        int   gaps;
        n_dat     = d;
        n_perr    = (^d) ^ pbit;
        n_ferr    = ~stopb;
        msb_first = msb;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)          b = 1'b0;
            else if (i <= W)     b = msb ? d[W-i] : d[i-1];
            else if (i == W + 1) b = pbit;
            else                 b = stopb;
            last = (i == W + 2);
            tick(b, 1'b1, rdy_for(rmode, last), last, !last);
            // Changing the order mid-frame must not affect this frame.
            if (i == 0) msb_first = logic'($urandom_range(0, 1));
            gaps = (en_mode == 0) ? 0 : (en_mode == 1) ? 1 : $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++)
                tick(logic'($urandom_range(0, 1)), 1'b0, rdy_for(rmode, 1'b0), 1'b0, !last);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_p_dout"}, p_dout, 32'd0);
        chk({tag, "_valid"}, dout_valid, 32'd0);
        chk({tag, "_perr"}, parity_err, 32'd0);
        chk({tag, "_ferr"}, frame_err, 32'd0);
        chk({tag, "_ovr"}, overrun, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
    endtask

    initial begin
        int ovr_before;
        logic [W-1:0] d;
        bit msb, pbit, stopb;

        #2 rst_n = 1'b0;
        #10;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2, 1'b1);

        // MSB-first, continuous qualifier, consumer always ready.
        send_frame(16'hA5C3, 1'b1, 1'b0, 1'b1, 0, 1, W + 3);
        idle(2, 1'b1);

        // LSB-first with alternating qualifier.
        send_frame(16'h0001, 1'b0, 1'b1, 1'b1, 1, 1, W + 3);
        idle(2, 1'b1);

        // Bad parity, then bad stop bit; the low stop bit must not start a new frame.
        send_frame(16'hA5C3, 1'b1, 1'b1, 1'b1, 0, 1, W + 3);
        idle(1, 1'b1);
        send_frame(16'h5A3C, 1'b0, 1'b0, 1'b0, 0, 1, W + 3);
        idle(3, 1'b1);

        // Back-to-back frames with consumer stalled: second one is dropped.
        ovr_before = ovr_seen;
        send_frame(16'h1234, 1'b1, 1'b1, 1'b1, 0, 0, W + 3);
        send_frame(16'hFFFF, 1'b1, 1'b0, 1'b1, 0, 0, W + 3);
        chk("overrun_count", ovr_seen - ovr_before, 32'd1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Accept on exactly the stop-bit edge of the following frame.
        send_frame(16'hBEEF, 1'b0, 1'b0, 1'b1, 0, 0, W + 3);
        ovr_before = ovr_seen;
        send_frame(16'h0F0F, 1'b1, 1'b0, 1'b1, 0, 3, W + 3);
        chk("stop_edge_no_overrun", ovr_seen - ovr_before, 32'd0);
        idle(2, 1'b1);

        // Reset mid-frame while an errored word is held.
        send_frame(16'hC0DE, 1'b1, 1'b0, 1'b0, 0, 0, W + 3);
        send_frame(16'hDEAD, 1'b1, 1'b0, 1'b1, 0, 0, 9);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_vld = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        s_en = 1'b0;
        @(posedge clk);
        #1;
        send_frame(16'h00FF, 1'b1, 1'b0, 1'b1, 0, 1, W + 3);
        idle(2, 1'b1);

        // Randomized frames, qualifier patterns and consumer behaviour.
        for (int f = 0; f < 40; f++) begin
            d     = W'($urandom);
            msb   = bit'($urandom_range(0, 1));
            pbit  = (^d) ^ ($urandom_range(0, 5) == 0);
            stopb = ($urandom_range(0, 5) != 0);
            send_frame(d, msb, pbit, stopb, $urandom_range(0, 2), $urandom_range(0, 3), W + 3);
            idle($urandom_range(0, 2), logic'($urandom_range(0, 1)));
        end
        idle(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
